tl_release_sink: RTL and testbench

- Manager-side sink for TileLink channel C traffic issued by the L1 data cache's writeback and probe paths.
- Accepts Release, ReleaseData, ProbeAck and ProbeAckData messages.
- Assembles 4-beat dirty lines into a 512-bit line buffer and writes them to the backing store.
- Returns ReleaseAck on channel D for voluntary releases and reports probe completion to the probe issuer.

---
 rtl/tl_release_sink.sv | 186 ++++++++++++++++++
 tb/tb_tl_release_sink.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_release_sink.sv
// TileLink channel C sink: collects Release/ProbeAck traffic from the L1 D$,
// writes dirty lines to the backing store, and answers with ReleaseAck or probe completion.
`timescale 1ns/1ps

module tl_release_sink #(
    parameter int DATA_W   = 128,
    parameter int BEATS    = 4,
    parameter int ADDR_W   = 32,
    parameter int SOURCE_W = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      c_valid,
    output logic                      c_ready,
    input  logic [2:0]                c_opcode,
    input  logic [2:0]                c_param,
    input  logic [3:0]                c_size,
    input  logic [SOURCE_W-1:0]       c_source,
    input  logic [ADDR_W-1:0]         c_address,
    input  logic [DATA_W-1:0]         c_data,
    output logic                      wr_valid,
    input  logic                      wr_ready,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W*BEATS-1:0]   wr_data,
    output logic                      d_valid,
    input  logic                      d_ready,
    output logic [2:0]                d_opcode,
    output logic [SOURCE_W-1:0]       d_source,
    output logic                      probe_ack_valid,
    output logic [2:0]                probe_ack_param,
    output logic                      probe_ack_dirty
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [2:0] OP_PROBE_ACK      = 3'd4;
    localparam logic [2:0] OP_PROBE_ACK_DATA = 3'd5;
    localparam logic [2:0] OP_RELEASE        = 3'd6;
    localparam logic [2:0] OP_RELEASE_DATA   = 3'd7;
    localparam logic [2:0] OP_RELEASE_ACK    = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_ACK
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [2:0]            opcode_q, opcode_d;
    logic [2:0]            param_q, param_d;
    logic [SOURCE_W-1:0]   source_q, source_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  pa_valid_q, pa_valid_d;
    logic [2:0]            pa_param_q, pa_param_d;
    logic                  pa_dirty_q, pa_dirty_d;
    logic                  ready_en_q;
    logic [DATA_W-1:0]     buf_q [BEATS];
    logic                  buf_we;
    logic [CNT_W-1:0]      buf_idx;
    logic                  c_fire, wr_fire, d_fire;

    // Accepting no beat until the first edge after reset keeps c_ready low while reset is held.
    assign c_ready  = ready_en_q && (state_q == S_IDLE || state_q == S_COLLECT);
    assign wr_valid = (state_q == S_WRITE);
    assign d_valid  = (state_q == S_ACK);
    assign c_fire   = c_valid && c_ready;
    assign wr_fire  = wr_valid && wr_ready;
    assign d_fire   = d_valid && d_ready;

    assign wr_addr         = addr_q;
    assign d_opcode        = OP_RELEASE_ACK;
    assign d_source        = source_q;
    assign probe_ack_valid = pa_valid_q;
    assign probe_ack_param = pa_param_q;
    assign probe_ack_dirty = pa_dirty_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        opcode_d   = opcode_q;
        param_d    = param_q;
        source_d   = source_q;
        addr_d     = addr_q;
        pa_valid_d = 1'b0;
        pa_param_d = pa_param_q;
        pa_dirty_d = pa_dirty_q;
        buf_we     = 1'b0;
        buf_idx    = beat_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                // Opcodes 0-3 are not C-channel responses this sink handles; drop them silently.
                if (c_fire && c_opcode[2]) begin
                    opcode_d = c_opcode;
                    param_d  = c_param;
                    source_d = c_source;
                    addr_d   = {c_address[ADDR_W-1:6], 6'b0};
                    unique case (c_opcode)
                        OP_RELEASE_DATA, OP_PROBE_ACK_DATA: begin
                            buf_we     = 1'b1;
                            buf_idx    = '0;
                            beat_cnt_d = CNT_W'(1);
                            state_d    = S_COLLECT;
                        end
                        OP_RELEASE: state_d = S_ACK;
                        default: begin
                            pa_valid_d = 1'b1;
                            pa_param_d = c_param;
                            pa_dirty_d = 1'b0;
                        end
                    endcase
                end
            end
            S_COLLECT: begin
                if (c_fire) begin
                    buf_we = 1'b1;
                    if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
                        beat_cnt_d = '0;
                        state_d    = S_WRITE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_WRITE: begin
                if (wr_fire) begin
                    if (opcode_q == OP_RELEASE_DATA) begin
                        state_d = S_ACK;
                    end else begin
                        state_d    = S_IDLE;
                        pa_valid_d = 1'b1;
                        pa_param_d = param_q;
                        pa_dirty_d = 1'b1;
                    end
                end
            end
            S_ACK: begin
                if (d_fire) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            beat_cnt_q <= '0;
            opcode_q   <= '0;
            param_q    <= '0;
            source_q   <= '0;
            addr_q     <= '0;
            pa_valid_q <= 1'b0;
            pa_param_q <= '0;
            pa_dirty_q <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            opcode_q   <= opcode_d;
            param_q    <= param_d;
            source_q   <= source_d;
            addr_q     <= addr_d;
            pa_valid_q <= pa_valid_d;
            pa_param_q <= pa_param_d;
            pa_dirty_q <= pa_dirty_d;
            ready_en_q <= 1'b1;
        end
    end

    // NOTE: the line buffer has no reset; its contents are only visible after a full line is collected.
    always_ff @(posedge clock) begin
        if (buf_we) buf_q[buf_idx] <= c_data;
    end

    always_comb begin
        wr_data = '0;
        if (state_q == S_WRITE) begin
            for (int i = 0; i < BEATS; i++) wr_data[i*DATA_W +: DATA_W] = buf_q[i];
        end
    end

endmodule

// File: tb/tb_tl_release_sink.sv
// Self-checking bench for tl_release_sink: directed test-plan scenarios followed by
// randomized traffic scored against a message-level reference model.
`timescale 1ns/1ps

module tb_tl_release_sink;

    localparam int DATA_W   = 128;
    localparam int BEATS    = 4;
    localparam int ADDR_W   = 32;
    localparam int SOURCE_W = 3;
    localparam int LINE_W   = DATA_W * BEATS;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                c_valid = 1'b0;
    logic                c_ready;
    logic [2:0]          c_opcode = '0;
    logic [2:0]          c_param = '0;
    logic [3:0]          c_size = '0;
    logic [SOURCE_W-1:0] c_source = '0;
    logic [ADDR_W-1:0]   c_address = '0;
    logic [DATA_W-1:0]   c_data = '0;
    logic                wr_valid;
    logic                wr_ready = 1'b0;
    logic [ADDR_W-1:0]   wr_addr;
    logic [LINE_W-1:0]   wr_data;
    logic                d_valid;
    logic                d_ready = 1'b0;
    logic [2:0]          d_opcode;
    logic [SOURCE_W-1:0] d_source;
    logic                probe_ack_valid;
    logic [2:0]          probe_ack_param;
    logic                probe_ack_dirty;

    tl_release_sink #(
        .DATA_W(DATA_W), .BEATS(BEATS), .ADDR_W(ADDR_W), .SOURCE_W(SOURCE_W)
    ) dut (
        .clock(clock), .reset(reset),
        .c_valid(c_valid), .c_ready(c_ready), .c_opcode(c_opcode), .c_param(c_param),
        .c_size(c_size), .c_source(c_source), .c_address(c_address), .c_data(c_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_source(d_source),
        .probe_ack_valid(probe_ack_valid), .probe_ack_param(probe_ack_param),
        .probe_ack_dirty(probe_ack_dirty)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit rand_ready_en = 1'b0;

    typedef struct packed { logic [ADDR_W-1:0] addr; logic [LINE_W-1:0] data; } wr_t;
    typedef struct packed { logic [2:0] param; logic dirty; } pb_t;

    // Observed transactions, filled only by the monitor; tests index from a saved base.
    wr_t                 obs_wr_q[$];
    logic [SOURCE_W-1:0] obs_ack_q[$];
    pb_t                 obs_pb_q[$];

    always @(negedge clock) begin
        if (reset) begin
            if (wr_valid && wr_ready) obs_wr_q.push_back(wr_t'{addr: wr_addr, data: wr_data});
            if (d_valid && d_ready) obs_ack_q.push_back(d_source);
            if (probe_ack_valid) obs_pb_q.push_back(pb_t'{param: probe_ack_param, dirty: probe_ack_dirty});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
        if (rand_ready_en) begin
            wr_ready = ($urandom_range(0, 2) != 0);
            d_ready  = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic send_beat(input logic [2:0] op, input logic [2:0] prm,
                             input logic [SOURCE_W-1:0] src, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] data);
        bit done = 1'b0;
        c_valid = 1'b1; c_opcode = op; c_param = prm; c_source = src;
        c_address = addr; c_data = data; c_size = 4'd6;
        for (int i = 0; i < 300 && !done; i++) begin
            done = c_ready;
            step();
        end
        c_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_beat_timeout: op=%0d never accepted", op);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_beat(input int idx);
        logic [DATA_W-1:0] b;
        b = {$urandom(), $urandom(), $urandom(), $urandom()};
        b[7:0] = 8'(idx);
        return b;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        checks++; if (c_ready !== 1'b0) begin errors++; $display("FAIL reset_c_ready: got %b want 0", c_ready); end
        checks++; if ({wr_valid, d_valid, probe_ack_valid} !== 3'b000) begin errors++;
            $display("FAIL reset_valids: got %b want 000", {wr_valid, d_valid, probe_ack_valid}); end
        checks++; if ({d_source, probe_ack_param, probe_ack_dirty} !== '0) begin errors++;
            $display("FAIL reset_latched: d_source=%0d param=%0d dirty=%b want 0", d_source, probe_ack_param, probe_ack_dirty); end
        checks++; if (wr_addr !== '0 || wr_data !== '0) begin errors++;
            $display("FAIL reset_wr_bus: addr=%h want 0, data nonzero=%b", wr_addr, |wr_data); end
        reset = 1'b1;
        step();
        checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", c_ready); end
    endtask

    task automatic test_release_data();
        logic [DATA_W-1:0] b [BEATS];
        logic [LINE_W-1:0] line;
        int wb = obs_wr_q.size();
        int ab = obs_ack_q.size();
        int pb = obs_pb_q.size();
        for (int i = 0; i < BEATS; i++) b[i] = rand_beat(i);
        line = {b[3], b[2], b[1], b[0]};
        for (int i = 0; i < BEATS; i++) send_beat(3'd7, 3'd0, 3'd2, 32'h8000_1040, b[i]);
        checks++; if (wr_valid !== 1'b1 || c_ready !== 1'b0) begin errors++;
            $display("FAIL rd_write_req: wr_valid=%b c_ready=%b want 1/0", wr_valid, c_ready); end
        checks++; if (wr_addr !== 32'h8000_1040) begin errors++; $display("FAIL rd_wr_addr: got %h want 80001040", wr_addr); end
        checks++; if (wr_data[127:0] !== b[0] || wr_data[511:384] !== b[3] || wr_data !== line) begin errors++;
            $display("FAIL rd_wr_data: beat0 got %h want %h, beat3 got %h want %h", wr_data[127:0], b[0], wr_data[511:384], b[3]); end
        wr_ready = 1'b1; step(); wr_ready = 1'b0;
        checks++; if (wr_valid !== 1'b0 || d_valid !== 1'b1 || d_opcode !== 3'd6 || d_source !== 3'd2) begin errors++;
            $display("FAIL rd_ack: wr_valid=%b d_valid=%b op=%0d src=%0d want 0/1/6/2", wr_valid, d_valid, d_opcode, d_source); end
        d_ready = 1'b1; step(); d_ready = 1'b0;
        checks++; if (d_valid !== 1'b0 || c_ready !== 1'b1) begin errors++;
            $display("FAIL rd_done: d_valid=%b c_ready=%b want 0/1", d_valid, c_ready); end
        checks++; if (obs_wr_q.size() - wb != 1 || obs_ack_q.size() - ab != 1 || obs_pb_q.size() != pb) begin errors++;
            $display("FAIL rd_txn_count: writes=%0d acks=%0d probes=%0d want 1/1/0",
                     obs_wr_q.size() - wb, obs_ack_q.size() - ab, obs_pb_q.size() - pb); end
    endtask

    task automatic test_release();
        int wb = obs_wr_q.size();
        send_beat(3'd6, 3'd1, 3'd5, 32'h1234_5678, rand_beat(0));
        checks++; if (d_valid !== 1'b1 || d_source !== 3'd5 || wr_valid !== 1'b0) begin errors++;
            $display("FAIL rel_ack: d_valid=%b src=%0d wr_valid=%b want 1/5/0", d_valid, d_source, wr_valid); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (d_valid !== 1'b1 || c_ready !== 1'b0) begin errors++;
                $display("FAIL rel_hold: cycle %0d d_valid=%b c_ready=%b want 1/0", i, d_valid, c_ready); end
        end
        d_ready = 1'b1; step(); d_ready = 1'b0;
        checks++; if (d_valid !== 1'b0 || c_ready !== 1'b1 || obs_wr_q.size() != wb) begin errors++;
            $display("FAIL rel_done: d_valid=%b c_ready=%b writes=%0d want 0/1/0", d_valid, c_ready, obs_wr_q.size() - wb); end
    endtask

    task automatic test_probe_ack_data();
        logic [DATA_W-1:0] b [BEATS];
        logic [LINE_W-1:0] line;
        logic [ADDR_W-1:0] addr = $urandom();
        int ab = obs_ack_q.size();
        for (int i = 0; i < BEATS; i++) b[i] = rand_beat(i);
        line = {b[3], b[2], b[1], b[0]};
        for (int i = 0; i < BEATS; i++) begin
            send_beat(3'd5, 3'd1, 3'd3, addr, b[i]);
            if (i != BEATS - 1) repeat ($urandom_range(1, 2)) step();
        end
        for (int i = 0; i < 2; i++) begin
            checks++; if (wr_valid !== 1'b1 || wr_data !== line || wr_addr !== {addr[31:6], 6'b0}) begin errors++;
                $display("FAIL pad_stall: cycle %0d wr_valid=%b addr=%h want %h, data match=%b", i, wr_valid, wr_addr,
                         {addr[31:6], 6'b0}, wr_data === line); end
            step();
        end
        wr_ready = 1'b1; step(); wr_ready = 1'b0;
        checks++; if (probe_ack_valid !== 1'b1 || probe_ack_param !== 3'd1 || probe_ack_dirty !== 1'b1) begin errors++;
            $display("FAIL pad_pulse: valid=%b param=%0d dirty=%b want 1/1/1", probe_ack_valid, probe_ack_param, probe_ack_dirty); end
        checks++; if (d_valid !== 1'b0 || c_ready !== 1'b1) begin errors++;
            $display("FAIL pad_state: d_valid=%b c_ready=%b want 0/1", d_valid, c_ready); end
        step();
        checks++; if (probe_ack_valid !== 1'b0 || probe_ack_param !== 3'd1 || probe_ack_dirty !== 1'b1) begin errors++;
            $display("FAIL pad_one_cycle: valid=%b param=%0d dirty=%b want 0/1/1", probe_ack_valid, probe_ack_param, probe_ack_dirty); end
        checks++; if (obs_ack_q.size() != ab) begin errors++; $display("FAIL pad_no_d: acks=%0d want 0", obs_ack_q.size() - ab); end
    endtask

    task automatic test_probe_ack(input logic [ADDR_W-1:0] addr);
        int wb = obs_wr_q.size();
        send_beat(3'd4, 3'd3, 3'd4, addr, rand_beat(0));
        checks++; if (probe_ack_valid !== 1'b1 || probe_ack_param !== 3'd3 || probe_ack_dirty !== 1'b0) begin errors++;
            $display("FAIL pa_pulse: valid=%b param=%0d dirty=%b want 1/3/0", probe_ack_valid, probe_ack_param, probe_ack_dirty); end
        checks++; if (c_ready !== 1'b1 || wr_valid !== 1'b0 || d_valid !== 1'b0) begin errors++;
            $display("FAIL pa_state: c_ready=%b wr_valid=%b d_valid=%b want 1/0/0", c_ready, wr_valid, d_valid); end
        step();
        checks++; if (probe_ack_valid !== 1'b0 || obs_wr_q.size() != wb) begin errors++;
            $display("FAIL pa_one_cycle: valid=%b writes=%0d want 0/0", probe_ack_valid, obs_wr_q.size() - wb); end
    endtask

    // Runs right after test_probe_ack, so the latched outputs are that message's values.
    task automatic test_ignored_opcode(input logic [ADDR_W-1:0] prev_addr);
        int pb = obs_pb_q.size();
        checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL ign_ready: got %b want 1", c_ready); end
        send_beat(3'd2, 3'd5, 3'd1, ~prev_addr, rand_beat(0));
        checks++; if (c_ready !== 1'b1 || wr_valid !== 1'b0 || d_valid !== 1'b0 || probe_ack_valid !== 1'b0) begin errors++;
            $display("FAIL ign_valids: c_ready=%b wr=%b d=%b pa=%b want 1/0/0/0", c_ready, wr_valid, d_valid, probe_ack_valid); end
        checks++; if (d_source !== 3'd4 || probe_ack_param !== 3'd3 || probe_ack_dirty !== 1'b0 ||
                      wr_addr !== {prev_addr[31:6], 6'b0}) begin errors++;
            $display("FAIL ign_latched: src=%0d param=%0d dirty=%b addr=%h want 4/3/0/%h", d_source, probe_ack_param,
                     probe_ack_dirty, wr_addr, {prev_addr[31:6], 6'b0}); end
        step();
        checks++; if (obs_pb_q.size() != pb) begin errors++; $display("FAIL ign_no_pulse: pulses=%0d want 0", obs_pb_q.size() - pb); end
    endtask

    task automatic test_reset_midflight();
        int wb = obs_wr_q.size();
        int ab = obs_ack_q.size();
        for (int i = 0; i < 3; i++) send_beat(3'd7, 3'd0, 3'd1, 32'h0000_2000, rand_beat(i));
        #2 reset = 1'b0;
        #1;
        checks++; if ({c_ready, wr_valid, d_valid, probe_ack_valid} !== 4'b0 || d_source !== '0 ||
                      wr_addr !== '0 || wr_data !== '0 || probe_ack_param !== '0) begin errors++;
            $display("FAIL mid_reset_outputs: ready=%b wr=%b d=%b pa=%b src=%0d addr=%h want all 0",
                     c_ready, wr_valid, d_valid, probe_ack_valid, d_source, wr_addr); end
        step(); step();
        reset = 1'b1;
        send_beat(3'd6, 3'd0, 3'd6, 32'h0000_3000, rand_beat(0));
        checks++; if (d_valid !== 1'b1 || d_source !== 3'd6 || wr_valid !== 1'b0) begin errors++;
            $display("FAIL mid_fresh_ack: d_valid=%b src=%0d wr_valid=%b want 1/6/0", d_valid, d_source, wr_valid); end
        d_ready = 1'b1; step(); d_ready = 1'b0;
        checks++; if (obs_wr_q.size() != wb || obs_ack_q.size() - ab != 1) begin errors++;
            $display("FAIL mid_no_stale: writes=%0d acks=%0d want 0/1", obs_wr_q.size() - wb, obs_ack_q.size() - ab); end
    endtask

    task automatic test_random();
        wr_t                 exp_wr_q[$];
        logic [SOURCE_W-1:0] exp_ack_q[$];
        pb_t                 exp_pb_q[$];
        int wb = obs_wr_q.size();
        int ab = obs_ack_q.size();
        int pb = obs_pb_q.size();
        bit drained = 1'b0;
        rand_ready_en = 1'b1;
        for (int m = 0; m < 60; m++) begin
            logic [2:0]          op   = 3'($urandom_range(0, 7));
            logic [2:0]          prm  = 3'($urandom());
            logic [SOURCE_W-1:0] src  = SOURCE_W'($urandom());
            logic [ADDR_W-1:0]   addr = $urandom();
            logic [LINE_W-1:0]   line;
            logic [DATA_W-1:0]   beat;
            if (op == 3'd5 || op == 3'd7) begin
                for (int i = 0; i < BEATS; i++) begin
                    beat = rand_beat(i);
                    line[i*DATA_W +: DATA_W] = beat;
                    // Beats after the first carry junk header fields that must be ignored.
                    if (i == 0) send_beat(op, prm, src, addr, beat);
                    else        send_beat(3'($urandom()), 3'($urandom()), SOURCE_W'($urandom()), $urandom(), beat);
                    repeat ($urandom_range(0, 2)) step();
                end
                exp_wr_q.push_back(wr_t'{addr: {addr[31:6], 6'b0}, data: line});
                if (op == 3'd7) exp_ack_q.push_back(src);
                else            exp_pb_q.push_back(pb_t'{param: prm, dirty: 1'b1});
            end else begin
                send_beat(op, prm, src, addr, rand_beat(0));
                if (op == 3'd6) exp_ack_q.push_back(src);
                if (op == 3'd4) exp_pb_q.push_back(pb_t'{param: prm, dirty: 1'b0});
                repeat ($urandom_range(0, 1)) step();
            end
        end
        for (int i = 0; i < 500 && !drained; i++) begin
            drained = (obs_wr_q.size() - wb == exp_wr_q.size()) && (obs_ack_q.size() - ab == exp_ack_q.size()) &&
                      (obs_pb_q.size() - pb == exp_pb_q.size()) && c_ready;
            if (!drained) step();
        end
        rand_ready_en = 1'b0; wr_ready = 1'b0; d_ready = 1'b0;
        step();
        checks++; if (obs_wr_q.size() - wb != exp_wr_q.size()) begin errors++;
            $display("FAIL rnd_write_count: got %0d want %0d", obs_wr_q.size() - wb, exp_wr_q.size()); end
        checks++; if (obs_ack_q.size() - ab != exp_ack_q.size()) begin errors++;
            $display("FAIL rnd_ack_count: got %0d want %0d", obs_ack_q.size() - ab, exp_ack_q.size()); end
        checks++; if (obs_pb_q.size() - pb != exp_pb_q.size()) begin errors++;
            $display("FAIL rnd_probe_count: got %0d want %0d", obs_pb_q.size() - pb, exp_pb_q.size()); end
        for (int i = 0; i < exp_wr_q.size() && wb + i < obs_wr_q.size(); i++) begin
            checks++; if (obs_wr_q[wb + i] !== exp_wr_q[i]) begin errors++;
                $display("FAIL rnd_write[%0d]: addr got %h want %h, data match=%b", i, obs_wr_q[wb + i].addr,
                         exp_wr_q[i].addr, obs_wr_q[wb + i].data === exp_wr_q[i].data); end
        end
        for (int i = 0; i < exp_ack_q.size() && ab + i < obs_ack_q.size(); i++) begin
            checks++; if (obs_ack_q[ab + i] !== exp_ack_q[i]) begin errors++;
                $display("FAIL rnd_ack[%0d]: source got %0d want %0d", i, obs_ack_q[ab + i], exp_ack_q[i]); end
        end
        for (int i = 0; i < exp_pb_q.size() && pb + i < obs_pb_q.size(); i++) begin
            checks++; if (obs_pb_q[pb + i] !== exp_pb_q[i]) begin errors++;
                $display("FAIL rnd_probe[%0d]: param/dirty got %0d/%b want %0d/%b", i, obs_pb_q[pb + i].param,
                         obs_pb_q[pb + i].dirty, exp_pb_q[i].param, exp_pb_q[i].dirty); end
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] pa_addr;
        pa_addr = 32'hCAFE_0A7C;
        test_reset();
        test_release_data();
        test_release();
        test_probe_ack_data();
        test_probe_ack(pa_addr);
        test_ignored_opcode(pa_addr);
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
